// File: rtl/pow2_filter_encoder.sv
// pow2_filter_encoder: encodes signed weights as power-of-two shift codes and packs LANES codes per word
module pow2_filter_encoder #(
  parameter int LANES = 16,
  parameter int WEIGHT_W = 16,
  parameter int MAX_SHIFT = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WEIGHT_W-1:0]     in_weight,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*LANES-1:0]      out_data,
  output logic [$clog2(LANES):0]  out_lanes,
  output logic                    sat_seen
);
  localparam int CNT_W = LANES > 1 ? $clog2(LANES) : 1;
  localparam int LW = $clog2(LANES) + 1;
  localparam logic [6:0] MAX_S = 7'(MAX_SHIFT);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);
  logic advance, accept, in_neg;
  logic [WEIGHT_W:0] in_ext, in_mag;
  logic s1_v_q, s1_v_d, s1_neg_q, s1_neg_d, s1_zero_q, s1_zero_d, s1_last_q, s1_last_d;
  logic [WEIGHT_W:0] s1_mag_q, s1_mag_d;
  logic [5:0] msb;
  logic rnd, sat;
  logic [6:0] s_raw;
  logic [4:0] s_fin;
  logic [7:0] code;
  logic s2_v_q, s2_v_d, s2_last_q, s2_last_d, sat_seen_q, sat_seen_d;
  logic [7:0] s2_code_q, s2_code_d;
  logic wr, flush;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8*LANES-1:0] lanes_q, lanes_d, word, out_data_q, out_data_d;
  logic [LW-1:0] out_lanes_q, out_lanes_d;
  logic out_valid_q, out_valid_d;

  always_comb begin
    advance = ~(out_valid_q & ~out_ready);
    accept = in_valid & advance;
    in_neg = in_weight[WEIGHT_W-1];
    in_ext = {in_neg, in_weight};
    in_mag = in_neg ? -in_ext : in_ext;
    s1_v_d = advance ? accept : s1_v_q;
    s1_neg_d = accept ? in_neg : s1_neg_q;
    s1_mag_d = accept ? in_mag : s1_mag_q;
    s1_zero_d = accept ? ~|in_weight : s1_zero_q;
    s1_last_d = accept ? in_last : s1_last_q;
  end

  // round to the nearer power of two using the bit just below the MSB
  always_comb begin
    msb = '0;
    rnd = 1'b0;
    for (int i = 1; i <= WEIGHT_W; i++)
      if (s1_mag_q[i]) begin
        msb = 6'(i);
        rnd = s1_mag_q[i-1];
      end
    s_raw = {1'b0, msb} + 7'(rnd);
    sat = s_raw > MAX_S;
    s_fin = sat ? 5'(MAX_SHIFT) : s_raw[4:0];
    code = s1_zero_q ? 8'h40 : {s1_neg_q, 2'b00, s_fin};
    s2_v_d = advance ? s1_v_q : s2_v_q;
    s2_code_d = (advance & s1_v_q) ? code : s2_code_q;
    s2_last_d = (advance & s1_v_q) ? s1_last_q : s2_last_q;
    sat_seen_d = sat_seen_q | (advance & s1_v_q & sat);
  end

  always_comb begin
    wr = advance & s2_v_q;
    flush = wr & (s2_last_q | (cnt_q == LAST_LANE));
    lanes_d = lanes_q;
    if (wr) lanes_d[8*cnt_q +: 8] = s2_code_q;
    word = '0;
    for (int i = 0; i < LANES; i++)
      word[8*i +: 8] = (i <= int'(cnt_q)) ? lanes_d[8*i +: 8] : 8'h40;
    cnt_d = flush ? '0 : wr ? cnt_q + CNT_W'(1) : cnt_q;
    out_valid_d = advance ? flush : out_valid_q;
    out_data_d = flush ? word : out_data_q;
    out_lanes_d = flush ? LW'(cnt_q) + LW'(1) : out_lanes_q;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s1_v_q <= 1'b0;
      s1_neg_q <= 1'b0;
      s1_mag_q <= '0;
      s1_zero_q <= 1'b0;
      s1_last_q <= 1'b0;
      s2_v_q <= 1'b0;
      s2_code_q <= '0;
      s2_last_q <= 1'b0;
      sat_seen_q <= 1'b0;
      cnt_q <= '0;
      lanes_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_lanes_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s1_neg_q <= s1_neg_d;
      s1_mag_q <= s1_mag_d;
      s1_zero_q <= s1_zero_d;
      s1_last_q <= s1_last_d;
      s2_v_q <= s2_v_d;
      s2_code_q <= s2_code_d;
      s2_last_q <= s2_last_d;
      sat_seen_q <= sat_seen_d;
      cnt_q <= cnt_d;
      lanes_q <= lanes_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_lanes_q <= out_lanes_d;
    end

  assign in_ready = advance;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_lanes = out_lanes_q;
  assign sat_seen = sat_seen_q;
endmodule

// File: tb/tb_pow2_filter_encoder.sv
// tb_pow2_filter_encoder: directed bench for the power-of-two weight encoder/packer
module tb_pow2_filter_encoder;
  logic clk = 1'b0;
  logic rst, in_valid, in_last, out_ready;
  logic [15:0] in_weight;
  logic in_ready, out_valid, sat_seen;
  logic [127:0] out_data;
  logic [4:0] out_lanes;
  logic in_ready12, out_valid12, sat12;
  logic [127:0] out_data12;
  logic [4:0] out_lanes12;
  int checks = 0, errors = 0, cyc = 0, waits = 0, last_acc = 0;
  logic [127:0] wd[$], w12[$];
  logic [4:0] wl[$];
  int wc[$];
  logic [7:0] ec[$];

  pow2_filter_encoder dut (
    .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_weight(in_weight), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_lanes(out_lanes), .sat_seen(sat_seen)
  );
  pow2_filter_encoder #(.MAX_SHIFT(12)) dut12 (
    .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready12),
    .in_weight(in_weight), .in_last(in_last), .out_valid(out_valid12),
    .out_ready(out_ready), .out_data(out_data12), .out_lanes(out_lanes12), .sat_seen(sat12)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // a word is taken on the next rising edge when valid and ready are both high here
  always @(negedge clk)
    if (out_valid && out_ready) begin
      wd.push_back(out_data);
      w12.push_back(out_data12);
      wl.push_back(out_lanes);
      wc.push_back(cyc);
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] enc(input logic signed [15:0] w, input int maxs);
    longint m;
    int p, s;
    m = w < 0 ? -longint'(w) : longint'(w);
    if (m == 0) return 8'h40;
    p = 0;
    while ((longint'(1) << (p + 1)) <= m) p++;
    s = p;
    if (p >= 1 && m >= (longint'(3) << (p - 1))) s = p + 1;
    if (s > maxs) s = maxs;
    return {(w < 0) ? 1'b1 : 1'b0, 2'b00, 5'(s)};
  endfunction

  function automatic logic [127:0] mkword(input int start, input int n);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = (i < n) ? ec[start + i] : 8'h40;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] w, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_weight = w;
    in_last = last;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      waits++;
      @(negedge clk);
    end
    chk("send_ready", in_ready, 1);
    ec.push_back(enc(w, 15));
    @(posedge clk);
    #1;
    last_acc = cyc;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (wd.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("word_count", wd.size(), n);
    idle(2);
  endtask

  task automatic clear();
    wd.delete();
    w12.delete();
    wl.delete();
    wc.delete();
    ec.delete();
  endtask

  initial begin
    int t1w[8] = '{0, 1, -1, 2, 3, -4, 5, 6};
    int t3w[5] = '{7, -9, 100, -1000, 20000};
    int a16 = 0;
    logic [7:0] lane0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_weight = '0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_lanes", out_lanes, 0);
    chk("rst_sat_seen", sat_seen, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    clear();
    for (int i = 0; i < 8; i++) send(16'(t1w[i]), i == 7);
    wait_words(1);
    chk("t1_data", wd[0], 128'h40404040404040400302820201800040);
    chk("t1_lanes", wl[0], 8);
    chk("t1_sat", sat_seen, 0);

    clear();
    send(16'h8000, 1'b1);
    send(16'h7fff, 1'b1);
    wait_words(2);
    chk("t2_neg_max15", wd[0], {{15{8'h40}}, 8'h8F});
    chk("t2_pos_max15", wd[1], {{15{8'h40}}, 8'h0F});
    chk("t2_neg_max12", w12[0], {{15{8'h40}}, 8'h8C});
    chk("t2_pos_max12", w12[1], {{15{8'h40}}, 8'h0C});
    chk("t2_lanes", wl[1], 1);
    chk("t2_sat15", sat_seen, 0);
    chk("t2_sat12", sat12, 1);
    chk("t2_idle12", {in_ready12, out_valid12, out_lanes12}, {1'b1, 1'b0, 5'd1});

    clear();
    for (int i = 0; i < 5; i++) send(16'(t3w[i]), i == 4);
    wait_words(1);
    chk("t3_data", wd[0], {{11{8'h40}}, 8'h0E, 8'h8A, 8'h07, 8'h83, 8'h03});
    chk("t3_lanes", wl[0], 5);
    send(16'd12, 1'b1);
    wait_words(2);
    chk("t3_fresh_word", wd[1], {{15{8'h40}}, 8'h04});
    chk("t3_fresh_lanes", wl[1], 1);
    chk("t3_sat12_sticky", sat12, 1);

    clear();
    fork
      for (int i = 0; i < 48; i++) send(16'(i * 613 - 14000), 1'b0);
      begin
        int k = 0;
        logic [127:0] snap;
        idle(17);
        out_ready = 1'b0;
        while (!out_valid && k < 50) begin
          @(negedge clk);
          k++;
        end
        chk("t4_stall_valid", out_valid, 1);
        snap = out_data;
        for (int j = 0; j < 10; j++) begin
          chk("t4_in_ready_low", in_ready, 0);
          chk("t4_data_stable", out_data, snap);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_words(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4_w%0d_data", i), wd[i], mkword(16 * i, 16));
      chk($sformatf("t4_w%0d_lanes", i), wl[i], 16);
    end
    idle(20);
    chk("t4_no_dup", wd.size(), 3);

    clear();
    for (int i = 0; i < 7; i++) send(16'(i * 100 + 1), 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t5_sat12_cleared", sat12, 0);
    idle(6);
    chk("t5_no_word", wd.size(), 0);
    chk("t5_out_valid", out_valid, 0);
    ec.delete();
    for (int i = 0; i < 16; i++) send(16'(-500 + i * 71), 1'b0);
    wait_words(1);
    chk("t5_data", wd[0], mkword(0, 16));
    lane0 = wd[0][7:0];
    chk("t5_lane0", lane0, 8'h89);
    chk("t5_lanes", wl[0], 16);

    clear();
    waits = 0;
    for (int i = 0; i < 64; i++) begin
      send(16'(i * 1021 - 32000), 1'b0);
      if (i == 15) a16 = last_acc;
    end
    chk("t6_no_stall", waits, 0);
    wait_words(4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_w%0d_cycle", i), wc[i], a16 + 2 + 16 * i);
      chk($sformatf("t6_w%0d_data", i), wd[i], mkword(16 * i, 16));
    end
    chk("t6_sat", sat_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
